async_queue_source: RTL

Enqueue-side (writer) end of the clock-domain-crossing queue: accepts a ready/valid stream in its own clock domain and writes it into an 8-entry storage array that the dequeue domain reads directly. It publishes a Gray-coded write index and receives the Gray-coded read index back from the sink domain. The read index is resynchronised locally through a 4-bit, 3-stage async-reset synchroniser. Sits between an enqueuing producer and the matching dequeue-side block in the other clock domain.

---
 rtl/async_queue_source_pkg.sv | 10 +
 rtl/async_queue_source_if.sv | 11 +
 rtl/async_queue_source_sync.sv | 21 ++
 rtl/async_queue_source.sv | 43 ++++
 4 files changed

// File: rtl/async_queue_source_pkg.sv
// async_queue_source_pkg: shared queue geometry, Gray conversion and full-compare mask
package async_queue_source_pkg;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] FULL_MASK = {2'b11, {(PTR_W-2){1'b0}}};
  function automatic logic [PTR_W-1:0] gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/async_queue_source_if.sv
// async_queue_source_if: enqueue stream (valid/bits/ready) plus crossing bus (mem, widx out, ridx in)
interface async_queue_source_if import async_queue_source_pkg::*; #(parameter int DATA_W = 32) ();
  logic                    io_enq_valid;
  logic [DATA_W-1:0]       io_enq_bits;
  logic                    io_enq_ready;
  logic [DEPTH*DATA_W-1:0] io_async_mem;
  logic [PTR_W-1:0]        io_async_widx;
  logic [PTR_W-1:0]        io_async_ridx;
  modport slave (input io_enq_valid, io_enq_bits, io_async_ridx, output io_enq_ready, io_async_mem, io_async_widx);
  modport master (output io_enq_valid, io_enq_bits, io_async_ridx, input io_enq_ready, io_async_mem, io_async_widx);
endinterface

// File: rtl/async_queue_source_sync.sv
// async_reset_sync_ptr: W-bit, STAGES-deep async-reset flop chain (clock, reset, d in, q out)
module async_reset_sync_ptr #(
  parameter int W = 4,
  parameter int STAGES = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sync_q [STAGES];
  logic [W-1:0] sync_d [STAGES];
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) sync_q <= '{default: '0};
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/async_queue_source.sv
// async_queue_source: writer end of CDC queue (clock, reset, q: enq stream in, mem/widx out, ridx in)
module async_queue_source import async_queue_source_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int SYNC_STAGES = 3
) (
  input logic clock,
  input logic reset,
  async_queue_source_if.slave q
);
  logic [PTR_W-1:0]  wptr_q, wptr_d, widx_q, widx_d, ridx_s;
  logic              ready_q, ready_d, fire;
  logic [DATA_W-1:0] mem_q [DEPTH];
  async_reset_sync_ptr #(.W(PTR_W), .STAGES(SYNC_STAGES)) u_sync (
    .clock(clock),
    .reset(reset),
    .d(q.io_async_ridx),
    .q(ridx_s)
  );
  // Full when the post-fire write index is exactly one lap ahead of the synchronised read index.
  always_comb begin
    fire = q.io_enq_valid && ready_q;
    wptr_d = wptr_q + PTR_W'(fire);
    widx_d = gray(wptr_d);
    ready_d = widx_d != (ridx_s ^ FULL_MASK);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wptr_q <= '0;
      widx_q <= '0;
      ready_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      widx_q <= widx_d;
      ready_q <= ready_d;
    end
  always_ff @(posedge clock)
    if (fire) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= q.io_enq_bits;
  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    assign q.io_async_mem[i*DATA_W +: DATA_W] = mem_q[i];
  end
  assign q.io_async_widx = widx_q;
  assign q.io_enq_ready = ready_q;
endmodule
